wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Writeback stage of the riscv_core pipeline, directly upstream of reg_file.
//  Accepts retiring instructions from MEM, selects ALU / PC+4 / load data,
//  aligns and sign-extends variable-latency load responses, and drives
//  reg_file's we/wa/wd. Re-exports the write as a bypass for decode, and
//  counts retired instructions.
// PARAMETERS
//  LD_TIMEOUT  64  cycles to wait for ld_rvalid before abandoning a load (>=2)
//  CNT_W       32  width of instret counter
// PORTS
//  clk          in   1      core clock; all state on posedge
//  rst          in   1      reset, asynchronous, active-high
//  in_valid     in   1      MEM presents an instruction
//  in_ready     out  1      stage can accept; = (state==IDLE)
//  in_rd        in   5      destination register
//  in_rd_we     in   1      instruction writes rd
//  in_wb_sel    in   2      00 ALU, 01 PC+4, 10 LOAD, 11 reserved (=ALU)
//  in_alu       in   32     ALU result
//  in_pc4       in   32     PC+4
//  in_funct3    in   3      load type
//  in_addr_lo   in   2      load byte address [1:0]
//  ld_rvalid    in   1      load response valid (one-cycle pulse)
//  ld_rdata     in   32     raw word-aligned load data
//  rf_we        out  1      to reg_file.we
//  rf_wa        out  5      to reg_file.wa
//  rf_wd        out  32     to reg_file.wd
//  fwd_valid    out  1      = rf_we; bypass for decode operand muxes
//  fwd_rd       out  5      = rf_wa
//  fwd_data     out  32     = rf_wd
//  instret      out  CNT_W  retired-instruction count, wraps
//  err          out  1      sticky: load timeout or unsolicited ld_rvalid
// BEHAVIOUR
//  - Reset: state IDLE, rf_we=0, rf_wa=0, rf_wd=0, instret=0, err=0, timer=0.
//  - rf_*/fwd_* are registered; valid for exactly one cycle per write.
//  - Accept = in_valid && in_ready. IDLE accept, wb_sel!=LOAD: next cycle
//    rf_we = in_rd_we && (in_rd!=0), rf_wa=in_rd, rf_wd=selected; instret+1.
//  - IDLE accept, wb_sel==LOAD: latch rd, rd_we, funct3, addr_lo; go WAIT,
//    timer=0; rf_we=0 next cycle. A response in the accept cycle is not ours.
//  - WAIT: in_ready=0, timer++ each cycle. On ld_rvalid: next cycle write
//    extracted data (rf_we gated by rd_we && rd!=0), instret+1, go IDLE.
//    In that IDLE cycle a new instruction may be accepted (back-to-back ok).
//  - WAIT timeout: timer reaches LD_TIMEOUT-1 without ld_rvalid -> IDLE,
//    no write, no instret, err=1. Response and timeout same cycle: response.
//  - ld_rvalid while IDLE -> ignored for data, err=1.
//  - Extraction: byte b = ld_rdata[8*addr_lo +: 8], half h =
//    ld_rdata[16*addr_lo[1] +: 16]. 000 LB sext(b); 001 LH sext(h); 100 LBU
//    zext(b); 101 LHU zext(h); 010 and all others LW (addr_lo ignored).
//  - x0 never written: rf_we=0 when rd==0, but instret still increments.
//  - instret wraps modulo 2^CNT_W. err clears only on rst.
//  - rst mid-WAIT: immediate return to IDLE, pending load dropped.
// TESTING
//  1 ALU: accept rd=5 wb_sel=00 alu=0xDEADBEEF -> next cycle rf_we=1 wa=5
//    wd=0xDEADBEEF, fwd_* equal, instret=1; following cycle rf_we=0.
//  2 Loads: LB addr_lo=3 rdata=0x80112233 -> wd=0xFFFFFF80; LHU addr_lo=2
//    -> 0x00008011; LH addr_lo=0 rdata=0x0000F00F -> 0xFFFFF00F.
//  3 Latency: LW rd=7, ld_rvalid 5 cycles later -> in_ready=0 for those
//    cycles, write 1 cycle after rvalid; second ALU op accepted that cycle.
//  4 x0: ALU op rd=0 rd_we=1 -> rf_we stays 0, instret increments.
//  5 Timeout: LOAD, no rvalid for LD_TIMEOUT cycles -> err=1, in_ready=1,
//    no write; later unsolicited rvalid keeps err=1, no write.
//  6 Reset: assert rst asynchronously mid-WAIT -> all outputs 0 immediately,
//    in_ready=1 once IDLE.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM issue, load response, reg_file write, bypass and status.
// The master modport is the upstream/observer side; the slave modport is wb_stage.
interface wb_stage_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic             in_rd_we;
  logic [1:0]       in_wb_sel;
  logic [31:0]      in_alu;
  logic [31:0]      in_pc4;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic             ld_rvalid;
  logic [31:0]      ld_rdata;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [31:0]      rf_wd;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [31:0]      fwd_data;
  logic [CNT_W-1:0] instret;
  logic             err;

  modport master (
    output in_valid, in_rd, in_rd_we, in_wb_sel, in_alu, in_pc4, in_funct3, in_addr_lo,
    output ld_rvalid, ld_rdata,
    input  in_ready, rf_we, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data, instret, err
  );

  modport slave (
    input  in_valid, in_rd, in_rd_we, in_wb_sel, in_alu, in_pc4, in_funct3, in_addr_lo,
    input  ld_rvalid, ld_rdata,
    output in_ready, rf_we, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data, instret, err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / PC+4 / load data, waits for variable-latency loads,
// drives the registered reg_file write and its decode bypass, counts retired instructions.
module wb_stage #(
  parameter int unsigned LD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);
  localparam int unsigned TW = $clog2(LD_TIMEOUT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           r_state, w_state_nx;
  logic             w_in_ready, w_accept, w_is_load, w_timeout;
  logic [TW-1:0]    r_timer;
  logic [4:0]       r_rd;
  logic             r_rd_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_rf_we;
  logic [4:0]       r_rf_wa;
  logic [31:0]      r_rf_wd;
  logic [CNT_W-1:0] r_instret;
  logic             r_err;
  logic [31:0]      w_sel_data, w_ld_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_is_load = (bus.in_wb_sel == 2'b10);
  assign w_timeout = (r_timer == TW'(LD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle: if (w_accept && w_is_load)         w_state_nx = StWait;
      StWait: if (bus.ld_rvalid || w_timeout)    w_state_nx = StIdle;
      default:                                   w_state_nx = StIdle;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == StIdle);
  end

  // Reserved wb_sel 11 behaves as ALU.
  assign w_sel_data = (bus.in_wb_sel == 2'b01) ? bus.in_pc4 : bus.in_alu;

  always_comb begin
    w_byte = bus.ld_rdata[{r_addr_lo, 3'b000} +: 8];
    w_half = bus.ld_rdata[{r_addr_lo[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.ld_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer   <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      r_rf_we   <= 1'b0;
      r_rf_wa   <= '0;
      r_rf_wd   <= '0;
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Any response while idle, including the load accept cycle, is unsolicited.
          if (bus.ld_rvalid) r_err <= 1'b1;
          if (w_accept) begin
            if (w_is_load) begin
              r_rd      <= bus.in_rd;
              r_rd_we   <= bus.in_rd_we;
              r_funct3  <= bus.in_funct3;
              r_addr_lo <= bus.in_addr_lo;
              r_timer   <= '0;
            end else begin
              r_rf_we   <= bus.in_rd_we && (bus.in_rd != 5'd0);
              r_rf_wa   <= bus.in_rd;
              r_rf_wd   <= w_sel_data;
              r_instret <= r_instret + CNT_W'(1);
            end
          end
        end
        StWait: begin
          r_timer <= r_timer + TW'(1);
          if (bus.ld_rvalid) begin
            r_rf_we   <= r_rd_we && (r_rd != 5'd0);
            r_rf_wa   <= r_rd;
            r_rf_wd   <= w_ld_data;
            r_instret <= r_instret + CNT_W'(1);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_wa     = r_rf_wa;
  assign bus.rf_wd     = r_rf_wd;
  assign bus.fwd_valid = r_rf_we;
  assign bus.fwd_rd    = r_rf_wa;
  assign bus.fwd_data  = r_rf_wd;
  assign bus.instret   = r_instret;
  assign bus.err       = r_err;
endmodule
